// File: rtl/sine_sched_pkg.sv
// Shared types and helpers for the sine request scheduler and its arbiter.
package sine_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StRecover,
    StResp
  } sched_state_e;

  // Ceiling log2, usable in constant expressions; returns 0 for values <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i, wrapping.
module rr_arbiter
  import sine_sched_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid_o) begin
        cand = IdxW'((32'(ptr_i) + k) % N);
        if (req_i[cand]) begin
          valid_o     = 1'b1;
          idx_o       = cand;
          gnt_o[cand] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sine_req_scheduler.sv
// Time-shares one iterative sine core among N_REQ requesters, one request in flight,
// with a watchdog that resets a hung core and reports an error response.
module sine_req_scheduler
  import sine_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic                      Clk_i,
  input  logic                      Rst_n_i,
  input  logic [N_REQ-1:0]          Req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   Req_angle_i,
  output logic [N_REQ-1:0]          Req_ready_o,
  output logic                      Resp_valid_o,
  input  logic                      Resp_ready_i,
  output logic [clog2(N_REQ)-1:0]   Resp_id_o,
  output logic [DATA_W-1:0]         Resp_sine_o,
  output logic                      Resp_err_o,
  output logic                      Core_start_o,
  output logic                      Core_rst_o,
  output logic [DATA_W-1:0]         Core_angle_o,
  input  logic [DATA_W-1:0]         Core_sine_i,
  input  logic                      Core_done_i,
  output logic                      Busy_o
);

  localparam int unsigned IdW    = clog2(N_REQ);
  localparam int unsigned TimerW = clog2(TIMEOUT) + 1;
  localparam int unsigned RcW    = clog2(RECOVER_CYC) + 1;

  sched_state_e      state_q, state_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [DATA_W-1:0] angle_q, angle_d;
  logic [DATA_W-1:0] sine_q, sine_d;
  logic              err_q, err_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [RcW-1:0]    rcnt_q, rcnt_d;
  logic              core_rst_q;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IdW-1:0]    arb_idx;
  logic              arb_valid;
  logic [DATA_W-1:0] sel_angle;

  rr_arbiter #(
    .N    (N_REQ),
    .IdxW (IdW)
  ) u_arb (
    .req_i   (Req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign sel_angle = Req_angle_i[32'(arb_idx) * DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    angle_d     = angle_q;
    sine_d      = sine_q;
    err_d       = err_q;
    timer_d     = timer_q;
    rcnt_d      = rcnt_q;
    Req_ready_o = '0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          Req_ready_o = arb_gnt;
          angle_d     = sel_angle;
          id_d        = arb_idx;
          state_d     = StStart;
        end
      end
      StStart: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (Core_done_i) begin
          sine_d  = Core_sine_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          sine_d  = '0;
          err_d   = 1'b1;
          rcnt_d  = '0;
          state_d = StRecover;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRecover: begin
        if (rcnt_q == RcW'(RECOVER_CYC - 1)) begin
          state_d = StResp;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      StResp: begin
        if (Resp_ready_i) begin
          ptr_d   = (id_q == IdW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      id_q       <= '0;
      angle_q    <= '0;
      sine_q     <= '0;
      err_q      <= 1'b0;
      timer_q    <= '0;
      rcnt_q     <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      angle_q    <= angle_d;
      sine_q     <= sine_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
      rcnt_q     <= rcnt_d;
      // Keeps the core in reset until the first edge after Rst_n_i releases.
      core_rst_q <= 1'b0;
    end
  end

  assign Core_start_o = (state_q == StStart);
  assign Core_rst_o   = core_rst_q | (state_q == StRecover);
  assign Core_angle_o = angle_q;
  assign Resp_valid_o = (state_q == StResp);
  assign Resp_id_o    = id_q;
  assign Resp_sine_o  = sine_q;
  assign Resp_err_o   = err_q;
  assign Busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_sine_req_scheduler.sv
// Randomized bench for sine_req_scheduler with a transaction-timing reference model.
module tb_sine_req_scheduler;
  import sine_sched_pkg::*;

  localparam int NR   = 4;
  localparam int DW   = 16;
  localparam int TO   = 64;
  localparam int RC   = 2;
  localparam int IW   = clog2(NR);
  localparam int HANG = 1000000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_angle;
  logic [NR-1:0]    req_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic [IW-1:0]    resp_id;
  logic [DW-1:0]    resp_sine;
  logic             resp_err;
  logic             core_start;
  logic             core_rst;
  logic [DW-1:0]    core_angle;
  logic [DW-1:0]    core_sine;
  logic             core_done;
  logic             busy;

  always #5 clk = ~clk;

  sine_req_scheduler #(
    .N_REQ       (NR),
    .DATA_W      (DW),
    .TIMEOUT     (TO),
    .RECOVER_CYC (RC)
  ) dut (
    .Clk_i        (clk),
    .Rst_n_i      (rst_n),
    .Req_valid_i  (req_valid),
    .Req_angle_i  (req_angle),
    .Req_ready_o  (req_ready),
    .Resp_valid_o (resp_valid),
    .Resp_ready_i (resp_ready),
    .Resp_id_o    (resp_id),
    .Resp_sine_o  (resp_sine),
    .Resp_err_o   (resp_err),
    .Core_start_o (core_start),
    .Core_rst_o   (core_rst),
    .Core_angle_o (core_angle),
    .Core_sine_i  (core_sine),
    .Core_done_i  (core_done),
    .Busy_o       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Stimulus knobs
  int            gen_pct   = 0;
  int            rdy_pct   = 100;
  int            lat_fixed = 0;
  logic [NR-1:0] gen_mask  = '0;

  // Reference model: one transaction described by accept cycle, core latency, response cycle
  bit          m_free  = 1;
  bit          m_first = 0;
  int          m_A, m_R, m_lat;
  int          m_id;
  int          m_ptr   = 0;
  logic [DW-1:0] m_angle;
  bit          acc_now;
  int          acc_g;
  bit          clr_pending = 0;
  int          clr_g;

  // Core stand-in
  bit            c_active = 0;
  int            c_done_at;
  logic [DW-1:0] c_angle;
  bit            s_start, s_rst;
  logic [DW-1:0] s_angle;

  // Observations of the DUT for hand-computed checks
  int            obs_acc_cyc, obs_start_cyc, obs_rv_cyc;
  int            obs_hs_id, obs_hs_err;
  logic [DW-1:0] obs_hs_sine;
  int            n_hs = 0, n_acc = 0, crst_cnt = 0;
  bit            prev_rv = 0;
  int            hs_ids[$];

  function automatic logic [DW-1:0] sine_of(input logic [DW-1:0] a);
    return a * 16'd3 + 16'd1;
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic int pick_lat();
    int r;
    if (lat_fixed > 0) return lat_fixed;
    r = int'($urandom_range(9));
    if (r <= 6) return int'($urandom_range(20, 1));
    if (r == 7) return TO;
    if (r == 8) return TO - 1;
    return ($urandom_range(1) == 0) ? TO + 1 : HANG;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic [NR-1:0] e_rdy;
    bit e_rst, e_rv, e_err;
    int g;
    s_start = core_start;
    s_rst   = core_rst;
    s_angle = core_angle;
    if (!rst_n) begin
      acc_now = 0;
      prev_rv = 0;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_id", 32'(resp_id), 0);
      chk("rst_resp_sine", 32'(resp_sine), 0);
      chk("rst_resp_err", 32'(resp_err), 0);
      chk("rst_core_start", 32'(core_start), 0);
      chk("rst_core_angle", 32'(core_angle), 0);
      chk("rst_core_rst", 32'(core_rst), 1);
      chk("rst_busy", 32'(busy), 0);
      return;
    end
    if (req_ready != '0) begin
      n_acc++;
      obs_acc_cyc = cyc;
    end
    if (core_start) obs_start_cyc = cyc;
    if (core_rst) crst_cnt++;
    if (resp_valid && !prev_rv) obs_rv_cyc = cyc;
    if (resp_valid && resp_ready) begin
      n_hs++;
      obs_hs_id   = int'(resp_id);
      obs_hs_err  = int'(resp_err);
      obs_hs_sine = resp_sine;
      hs_ids.push_back(int'(resp_id));
    end
    prev_rv = resp_valid;

    e_rdy   = '0;
    acc_now = 0;
    if (m_free) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        acc_now  = 1;
        acc_g    = g;
        e_rdy[g] = 1'b1;
      end
    end
    e_err = (m_lat > TO);
    e_rst = m_first || (!m_free && e_err && cyc >= m_A + TO + 2 && cyc < m_R);
    e_rv  = !m_free && cyc >= m_R;
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("busy", 32'(busy), 32'(!m_free));
    chk("core_start", 32'(core_start), 32'(!m_free && cyc == m_A + 1));
    chk("core_rst", 32'(core_rst), 32'(e_rst));
    chk("resp_valid", 32'(resp_valid), 32'(e_rv));
    if (!m_free) chk("core_angle", 32'(core_angle), 32'(m_angle));
    if (e_rv) begin
      chk("resp_id", 32'(resp_id), 32'(m_id));
      chk("resp_err", 32'(resp_err), 32'(e_err));
      chk("resp_sine", 32'(resp_sine), e_err ? 32'd0 : 32'(sine_of(m_angle)));
    end
  endtask

  task automatic commit();
    if (!rst_n) begin
      m_free  = 1;
      m_ptr   = 0;
      m_first = 0;
    end else begin
      m_first = 0;
      if (acc_now) begin
        m_free      = 0;
        m_A         = cyc;
        m_id        = acc_g;
        m_angle     = req_angle[acc_g*DW +: DW];
        m_lat       = pick_lat();
        m_R         = (m_lat > TO) ? cyc + TO + 2 + RC : cyc + 2 + m_lat;
        clr_pending = 1;
        clr_g       = acc_g;
      end else if (!m_free && cyc >= m_R && resp_ready) begin
        m_free = 1;
        m_ptr  = (m_id + 1) % NR;
      end
    end
    if (s_rst) begin
      c_active = 0;
    end else if (s_start) begin
      c_active  = 1;
      c_done_at = cyc + m_lat;
      c_angle   = s_angle;
    end
    cyc++;
  endtask

  task automatic drive();
    if (clr_pending) begin
      req_valid[clr_g] = 1'b0;
      clr_pending = 0;
    end
    for (int i = 0; i < NR; i++) begin
      if (!req_valid[i] && gen_mask[i] && int'($urandom_range(99)) < gen_pct) begin
        req_valid[i] = 1'b1;
        req_angle[i*DW +: DW] = DW'($urandom);
      end
    end
    resp_ready = (int'($urandom_range(99)) < rdy_pct);
    if (c_active && cyc == c_done_at) begin
      core_done = 1'b1;
      core_sine = sine_of(c_angle);
    end else begin
      // An idle core may glitch Done; the scheduler must ignore it.
      core_done = !c_active && ($urandom_range(7) == 0);
      core_sine = DW'($urandom);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    commit();
    #1;
    drive();
  endtask

  task automatic inject(input int i, input logic [DW-1:0] a, input int lat);
    req_valid[i] = 1'b1;
    req_angle[i*DW +: DW] = a;
    lat_fixed = lat;
  endtask

  task automatic run_until_resp(input string nm, input int budget);
    int n0, k;
    n0 = n_hs;
    k  = 0;
    while (n_hs == n0 && k < budget) begin
      tick();
      k++;
    end
    chk({nm, "_arrived"}, 32'(n_hs != n0), 1);
  endtask

  task automatic do_reset(input int cycles);
    rst_n       = 1'b0;
    req_valid   = '0;
    clr_pending = 0;
    repeat (cycles) tick();
    rst_n   = 1'b1;
    m_first = 1;
  endtask

  initial begin
    int n0, a0;
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst_n = 1'b0; req_valid = '0; req_angle = '0; resp_ready = 1'b0;
    core_done = 1'b0; core_sine = '0;
    #2;
    do_reset(3);

    // Single request, fixed 16-cycle core.
    inject(0, 16'h1999, 16);
    run_until_resp("t1", 100);
    chk("t1_start_lat", 32'(obs_start_cyc - obs_acc_cyc), 1);
    chk("t1_resp_lat", 32'(obs_rv_cyc - obs_acc_cyc), 18);
    chk("t1_id", 32'(obs_hs_id), 0);
    chk("t1_sine", 32'(obs_hs_sine), 32'h4CCC);
    chk("t1_err", 32'(obs_hs_err), 0);

    // All requesters continuously valid from pointer 0.
    do_reset(2);
    lat_fixed = 3;
    gen_mask  = '1;
    gen_pct   = 100;
    for (int i = 0; i < NR; i++) inject(i, DW'($urandom), 3);
    hs_ids.delete();
    for (int k = 0; k < 8; k++) run_until_resp("t2", 50);
    gen_mask = '0;
    for (int k = 0; k < 8; k++) chk("t2_grant_order", 32'(hs_ids[k]), 32'(exp_order[k]));
    req_valid = '0;
    clr_pending = 0;
    tick();

    // Hung core: timeout, recovery, then a normal request.
    crst_cnt = 0;
    inject(1, 16'h0123, HANG);
    run_until_resp("t3", 200);
    chk("t3_resp_lat", 32'(obs_rv_cyc - obs_acc_cyc), TO + 2 + RC);
    chk("t3_err", 32'(obs_hs_err), 1);
    chk("t3_sine", 32'(obs_hs_sine), 0);
    chk("t3_core_rst_cycles", 32'(crst_cnt), RC);
    inject(2, 16'h0010, 5);
    run_until_resp("t3b", 50);
    chk("t3b_err", 32'(obs_hs_err), 0);
    chk("t3b_sine", 32'(obs_hs_sine), 32'h0031);
    chk("t3b_resp_lat", 32'(obs_rv_cyc - obs_acc_cyc), 7);

    // Response back-pressure while another requester waits.
    inject(3, 16'h0777, 2);
    tick();
    a0 = n_acc;
    n0 = n_hs;
    inject(0, 16'h0042, 2);
    rdy_pct = 0;
    repeat (14) tick();
    chk("t4_no_new_accept", 32'(n_acc - a0), 0);
    chk("t4_no_handshake", 32'(n_hs - n0), 0);
    chk("t4_resp_held", 32'(resp_valid), 1);
    rdy_pct = 100;
    run_until_resp("t4", 20);
    chk("t4_id", 32'(obs_hs_id), 3);
    run_until_resp("t4b", 20);
    chk("t4b_id", 32'(obs_hs_id), 0);

    // Done on the exact timeout cycle.
    crst_cnt = 0;
    inject(1, 16'h2000, TO);
    run_until_resp("t5", 200);
    chk("t5_err", 32'(obs_hs_err), 0);
    chk("t5_sine", 32'(obs_hs_sine), 32'h6001);
    chk("t5_resp_lat", 32'(obs_rv_cyc - obs_acc_cyc), TO + 2);
    chk("t5_core_rst_cycles", 32'(crst_cnt), 0);

    // Reset during WAIT discards the in-flight request and clears the pointer.
    inject(2, 16'h0555, 4);
    run_until_resp("t6a", 50);
    inject(3, 16'h0666, HANG);
    repeat (10) tick();
    n0 = n_hs;
    do_reset(2);
    inject(2, 16'h0100, 6);
    inject(3, 16'h0200, 6);
    run_until_resp("t6", 50);
    chk("t6_one_response", 32'(n_hs - n0), 1);
    chk("t6_id", 32'(obs_hs_id), 2);
    chk("t6_sine", 32'(obs_hs_sine), 32'h0301);
    run_until_resp("t6b", 50);
    chk("t6b_id", 32'(obs_hs_id), 3);

    // Randomized traffic.
    lat_fixed = 0;
    gen_mask  = '1;
    gen_pct   = 20;
    rdy_pct   = 70;
    repeat (4000) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
